fetch_unit: RTL
===============

Name: fetch_unit

Overview:
Parametrised instruction-fetch front end for the pipelined CPU.
- Loads the start PC from a reset vector in instruction memory.
- Fetches sequentially from a synchronous-read instruction memory and delivers instructions to decode over a valid/ready handshake.
- Handles branch redirects from later stages and interrupt entry through an interrupt vector.
- A one-entry skid buffer absorbs the in-flight memory response when decode stalls.

Parameters:
PC_WIDTH, 32, program counter and instruction-memory address width
INSTR_WIDTH, 16, instruction word width (divides PC_WIDTH)
RESET_VEC_ADDR, 0, address of reset-vector words
INT_VEC_ADDR, 2, address of interrupt-vector words

Ports:
i_clk  in  1  clock, rising edge
i_reset_n  in  1  asynchronous active-low reset
o_imem_en  out  1  memory read request this cycle
o_imem_addr  out  PC_WIDTH  read address (combinational from state/PC)
i_imem_data  in  INSTR_WIDTH  read data, valid the cycle after o_imem_en
o_valid  out  1  instruction available to decode
i_ready  in  1  decode accepts; transfer when o_valid && i_ready
o_instr  out  INSTR_WIDTH  instruction
o_pc  out  PC_WIDTH  address of o_instr
i_redirect  in  1  branch/jump redirect, one-cycle pulse
i_redirect_pc  in  PC_WIDTH  redirect target
i_interrupt  in  1  interrupt request, level
o_int_ack  out  1  one-cycle pulse when vector loaded
o_int_return_pc  out  PC_WIDTH  oldest undelivered PC at interrupt take, held until next take

Behaviour:
- Reset (async, while i_reset_n=0):
  - Outputs: o_valid=0, o_instr=0, o_pc=0, o_int_ack=0, o_int_return_pc=0.
  - Internal: PC=0, skid empty, in-flight flag cleared, state=S_VEC with base RESET_VEC_ADDR.
- Vector words: VW = PC_WIDTH/INSTR_WIDTH.
  - Word at base+k holds bits [(VW-k)*INSTR_WIDTH-1 -: INSTR_WIDTH]; most-significant word first.
  - VW=1 loads a single word.
- S_VEC:
  - Issues VW consecutive reads, one per cycle, at base..base+VW-1.
  - Assembles the returned words into PC.
  - After the last word returns, moves to S_RUN; pulses o_int_ack that cycle if base was INT_VEC_ADDR.
  - o_valid stays 0 throughout.
- S_RUN:
  - Issues a read at PC when the skid buffer is empty; PC <= PC+1, modulo 2^PC_WIDTH, wraps silently.
  - Responses fill the output register if it is empty or being consumed this cycle; otherwise they go to the skid buffer.
  - When the output register drains, the skid entry moves to the output register.
  - o_instr/o_pc are stable while o_valid && !i_ready.
- Sustained throughput is 1 instruction/cycle when i_ready=1. Latency from request to o_valid is 2 edges.
- Priority each cycle: reset > redirect > interrupt > sequential.
- i_redirect (any state other than reset):
  - Next edge: o_valid=0, skid cleared, in-flight response squashed, PC=i_redirect_pc, state=S_RUN.
  - First request at the new PC is the following cycle.
  - A redirect in S_VEC aborts the vector load.
- Interrupt take: i_interrupt=1 in S_RUN with no redirect.
  - o_int_return_pc <= oldest undelivered PC: o_pc if o_valid && !i_ready; else skid PC if skid full; else in-flight PC if a request is in flight; else PC.
  - Any instruction transferred that same cycle counts as delivered.
  - Pipeline squashed; state=S_VEC with base INT_VEC_ADDR.
  - Not re-taken in S_VEC. It is the requester's job to drop i_interrupt after o_int_ack.

Optional Feature:
FETCH_PERF_CNT_EN
- Defined: adds o_perf_fetched (32, count of handshake transfers) and o_perf_stall (32, cycles with o_valid && !i_ready).
  - Both reset to 0 and wrap at 2^32.
- Undefined: neither port nor the counters exist.

Decomposition:
- Package fetch_pkg:
  - State enum S_VEC, S_RUN.
  - Vector-word count function.
  - Default vector address constants.
- One sub-module, fetch_skid_buffer: single-entry {instr, pc} holding register with push/pop/flush and a full flag.

Test Plan:
- Reset vector (PC_WIDTH=32, INSTR_WIDTH=16, M[0]=0x0000, M[1]=0x0010) -> first transfer o_pc=0x10, then 0x11, 0x12 on consecutive cycles with i_ready=1. o_valid=0 before the first transfer.
- Backpressure: i_ready=0 for 3 cycles at o_pc=0x12 -> o_instr/o_pc held. On release, 0x12, 0x13, 0x14 delivered with no loss or duplicate; skid full flag observed.
- Redirect: i_redirect pulse with target 0x40 while 0x15 is in flight -> 0x15 never appears; next transfer o_pc=0x40.
- Interrupt: M[2]=0x0000, M[3]=0x0100; i_interrupt while o_pc=0x20 is stalled -> o_int_return_pc=0x20, one-cycle o_int_ack, next transfer o_pc=0x100.
- Simultaneous redirect + interrupt -> redirect wins, no o_int_ack. Interrupt taken the next cycle with o_int_return_pc = redirect target.
- Reset asserted mid-stream -> o_valid drops immediately (async). After release, restarts from the reset vector.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic {
        S_VEC = 1'b0,
        S_RUN = 1'b1
    } state_t;

    localparam int DEF_RESET_VEC_ADDR = 0;
    localparam int DEF_INT_VEC_ADDR   = 2;

    // Number of instruction words that make up one vector address.
    function automatic int vec_words(input int pc_w, input int instr_w);
        return pc_w / instr_w;
    endfunction

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry {instr, pc} holding register; push wins over pop, flush wins over both.
module fetch_skid_buffer #(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 16
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    input  logic                   i_push,
    input  logic                   i_pop,
    input  logic                   i_flush,
    input  logic [INSTR_WIDTH-1:0] i_instr,
    input  logic [PC_WIDTH-1:0]    i_pc,
    output logic                   o_full,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc
);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_full  <= 1'b0;
            o_instr <= '0;
            o_pc    <= '0;
        end else if (i_flush) begin
            o_full <= 1'b0;
        end else if (i_push) begin
            o_full  <= 1'b1;
            o_instr <= i_instr;
            o_pc    <= i_pc;
        end else if (i_pop) begin
            o_full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: vector load, sequential fetch, redirect, interrupt entry.
// Optional FETCH_PERF_CNT_EN adds transfer and stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int PC_WIDTH    = 32,
    parameter int INSTR_WIDTH = 16,
    parameter logic [PC_WIDTH-1:0] RESET_VEC_ADDR = PC_WIDTH'(DEF_RESET_VEC_ADDR),
    parameter logic [PC_WIDTH-1:0] INT_VEC_ADDR   = PC_WIDTH'(DEF_INT_VEC_ADDR)
) (
    input  logic                   i_clk,
    input  logic                   i_reset_n,
    output logic                   o_imem_en,
    output logic [PC_WIDTH-1:0]    o_imem_addr,
    input  logic [INSTR_WIDTH-1:0] i_imem_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [INSTR_WIDTH-1:0] o_instr,
    output logic [PC_WIDTH-1:0]    o_pc,
    input  logic                   i_redirect,
    input  logic [PC_WIDTH-1:0]    i_redirect_pc,
    input  logic                   i_interrupt,
    output logic                   o_int_ack,
    output logic [PC_WIDTH-1:0]    o_int_return_pc
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0]            o_perf_fetched,
    output logic [31:0]            o_perf_stall
`endif
);

    localparam int VW = vec_words(PC_WIDTH, INSTR_WIDTH);
    localparam int CW = $clog2(VW + 1);

    state_t                 state;
    logic                   vec_int;
    logic [CW-1:0]          req_cnt;
    logic [CW-1:0]          rsp_cnt;
    logic [PC_WIDTH-1:0]    pc;
    logic [PC_WIDTH-1:0]    inflight_pc;
    logic                   inflight;

    logic                   skid_push;
    logic                   skid_pop;
    logic                   skid_flush;
    logic                   skid_full;
    logic [INSTR_WIDTH-1:0] skid_instr;
    logic [PC_WIDTH-1:0]    skid_pc;

    logic                   stall;
    logic                   out_free;
    logic                   run_rsp;
    logic                   vec_rsp;
    logic                   vec_last;
    logic                   take_int;
    logic [PC_WIDTH-1:0]    vec_base;
    logic [PC_WIDTH-1:0]    ret_pc;

    assign stall    = o_valid && !i_ready;
    assign out_free = !o_valid || i_ready;
    assign run_rsp  = (state == S_RUN) && inflight;
    assign vec_rsp  = (state == S_VEC) && inflight;
    assign vec_last = vec_rsp && (rsp_cnt == CW'(VW - 1));
    assign take_int = !i_redirect && (state == S_RUN) && i_interrupt;
    assign vec_base = vec_int ? INT_VEC_ADDR : RESET_VEC_ADDR;

    // Oldest instruction not yet handed to decode.
    assign ret_pc = stall     ? o_pc :
                    skid_full ? skid_pc :
                    inflight  ? inflight_pc : pc;

    // Hold off a request whose response would find both registers occupied.
    always_comb begin
        o_imem_en   = 1'b0;
        o_imem_addr = pc;
        unique case (1'b1)
            state == S_VEC: begin
                o_imem_en   = req_cnt < CW'(VW);
                o_imem_addr = vec_base + PC_WIDTH'(req_cnt);
            end
            default: o_imem_en = !skid_full && !(inflight && stall);
        endcase
    end

    assign skid_flush = i_redirect || take_int;
    assign skid_pop   = (state == S_RUN) && skid_full && out_free;
    assign skid_push  = run_rsp && (stall || skid_full);

    fetch_skid_buffer #(
        .PC_WIDTH    (PC_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_skid (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_push    (skid_push),
        .i_pop     (skid_pop),
        .i_flush   (skid_flush),
        .i_instr   (i_imem_data),
        .i_pc      (inflight_pc),
        .o_full    (skid_full),
        .o_instr   (skid_instr),
        .o_pc      (skid_pc)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state           <= S_VEC;
            vec_int         <= 1'b0;
            req_cnt         <= '0;
            rsp_cnt         <= '0;
            pc              <= '0;
            inflight_pc     <= '0;
            inflight        <= 1'b0;
            o_valid         <= 1'b0;
            o_instr         <= '0;
            o_pc            <= '0;
            o_int_ack       <= 1'b0;
            o_int_return_pc <= '0;
        end else begin
            o_int_ack <= 1'b0;
            if (i_redirect) begin
                state    <= S_RUN;
                pc       <= i_redirect_pc;
                inflight <= 1'b0;
                o_valid  <= 1'b0;
            end else if (take_int) begin
                state           <= S_VEC;
                vec_int         <= 1'b1;
                req_cnt         <= '0;
                rsp_cnt         <= '0;
                inflight        <= 1'b0;
                o_valid         <= 1'b0;
                o_int_return_pc <= ret_pc;
            end else if (state == S_VEC) begin
                inflight <= o_imem_en;
                if (o_imem_en) req_cnt <= req_cnt + 1'b1;
                if (vec_rsp) begin
                    pc      <= (pc << INSTR_WIDTH) | PC_WIDTH'(i_imem_data);
                    rsp_cnt <= rsp_cnt + 1'b1;
                    if (vec_last) begin
                        state     <= S_RUN;
                        o_int_ack <= (vec_base == INT_VEC_ADDR);
                    end
                end
            end else begin
                inflight <= o_imem_en;
                if (o_imem_en) begin
                    inflight_pc <= pc;
                    pc          <= pc + 1'b1;
                end
                if (out_free) begin
                    if (skid_full) begin
                        o_valid <= 1'b1;
                        o_instr <= skid_instr;
                        o_pc    <= skid_pc;
                    end else if (inflight) begin
                        o_valid <= 1'b1;
                        o_instr <= i_imem_data;
                        o_pc    <= inflight_pc;
                    end else begin
                        o_valid <= 1'b0;
                    end
                end
            end
        end
    end

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_perf_fetched <= '0;
            o_perf_stall   <= '0;
        end else begin
            if (o_valid && i_ready) o_perf_fetched <= o_perf_fetched + 1'b1;
            if (stall) o_perf_stall <= o_perf_stall + 1'b1;
        end
    end
`endif

endmodule
